// File: rtl/rvvi_arb_pkg.sv
// Shared types and constants for the RVVI retirement arbiter.
//
// retire_entry_t is the unit stored in each per-hart buffer and carried to
// the output stage. Its PC field width follows the package XLEN, so the
// arbiter's XLEN parameter must be left equal to it.
//
// Contents:
//   XLEN            - PC width used by retire_entry_t
//   OVF_CNT_W       - width of each per-hart overflow counter
//   OVF_CNT_MAX     - saturation value of an overflow counter
//   retire_entry_t  - {pc, insn, order, trap}
//   ENTRY_W         - flattened width of retire_entry_t
package rvvi_arb_pkg;

    localparam int XLEN      = 64;
    localparam int OVF_CNT_W = 16;
    localparam logic [OVF_CNT_W-1:0] OVF_CNT_MAX = '1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     insn;
        logic [63:0]     order;
        logic            trap;
    } retire_entry_t;

    localparam int ENTRY_W = $bits(retire_entry_t);

endpackage

// File: rtl/rvvi_retire_fifo.sv
// Per-hart synchronous retirement buffer.
//
// Ports:
//   clk       in   clock, posedge
//   reset_n   in   synchronous active-low reset, empties the buffer
//   push      in   write data_in this cycle
//   pop       in   retire the head entry this cycle
//   data_in   in   ENTRY_W-bit packed retire_entry_t
//   data_out  out  head entry (valid while !empty)
//   full      out  DEPTH entries held
//   empty     out  no entries held
//
// A push while full is accepted only when a pop happens in the same cycle;
// otherwise it is ignored and the caller accounts for the drop.
module rvvi_retire_fifo
    import rvvi_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] data_in,
    output logic [ENTRY_W-1:0] data_out,
    output logic               full,
    output logic               empty
);

    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic               do_push;
    logic               do_pop;

    // The extra wrap bit distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign data_out = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: the pointers alone define which slots are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= data_in;
        end
    end

endmodule

// File: rtl/rvvi_retire_arbiter.sv
// Merges per-hart RVVI retirement events into one ordered stream.
//
// Each hart feeds its own rvvi_retire_fifo. A round-robin scheduler drains
// the buffers into a single registered output slot governed by
// out_valid/out_ready. The trace cannot be stalled, so an event arriving
// at a full buffer (with no pop that cycle) is dropped and counted.
//
// Ports:
//   clk, reset_n                 clock and synchronous active-low reset
//   in_valid/pc/insn/order/trap  per-hart retirement, flattened NHART-wide
//   out_valid, out_ready         output slot handshake
//   out_hart/pc/insn/order/trap  output slot contents
//   ovf_cnt                      per-hart 16-bit saturating drop counters
//   ovf_flag                     per-hart sticky drop flags
//   order_err                    per-hart sticky order-check errors
//
// Build option: define RVVI_ARB_ORDER_CHECK_EN to check that each accepted
// order value is the previous accepted one plus 1; otherwise order_err is 0.
module rvvi_retire_arbiter
    import rvvi_arb_pkg::*;
#(
    parameter int NHART = 2,
    parameter int XLEN  = 64,
    parameter int DEPTH = 4,
    localparam int HW   = (NHART > 1) ? $clog2(NHART) : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NHART-1:0]           in_valid,
    input  logic [NHART*XLEN-1:0]      in_pc,
    input  logic [NHART*32-1:0]        in_insn,
    input  logic [NHART*64-1:0]        in_order,
    input  logic [NHART-1:0]           in_trap,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [HW-1:0]              out_hart,
    output logic [XLEN-1:0]            out_pc,
    output logic [31:0]                out_insn,
    output logic [63:0]                out_order,
    output logic                       out_trap,
    output logic [NHART*OVF_CNT_W-1:0] ovf_cnt,
    output logic [NHART-1:0]           ovf_flag,
    output logic [NHART-1:0]           order_err
);

    logic [ENTRY_W-1:0] head_bits [NHART];
    logic [NHART-1:0]   full;
    logic [NHART-1:0]   empty;
    logic [NHART-1:0]   push;
    logic [NHART-1:0]   pop;
    logic [NHART-1:0]   drop;
    logic [HW-1:0]      rr_ptr;
    logic [HW-1:0]      grant;
    logic               grant_valid;
    logic               load;
    retire_entry_t      head;
    int                 idx;

    // The slot may take a new entry when it is empty or is being handed off.
    assign load = !out_valid || out_ready;

    // Round-robin scan starting at rr_ptr; the first non-empty buffer wins
    // and its head entry is steered toward the output slot.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        head        = '0;
        idx         = 0;
        for (int i = 0; i < NHART; i++) begin
            idx = (int'(rr_ptr) + i) % NHART;
            if (!grant_valid && !empty[idx]) begin
                grant_valid = 1'b1;
                grant       = idx[HW-1:0];
                head        = retire_entry_t'(head_bits[idx]);
            end
        end
    end

    for (genvar h = 0; h < NHART; h++) begin : g_hart
        retire_entry_t        entry_in;
        logic [OVF_CNT_W-1:0] cnt_q;
        logic                 flag_q;

        assign entry_in = {in_pc[h*XLEN +: XLEN], in_insn[h*32 +: 32],
                           in_order[h*64 +: 64], in_trap[h]};

        // A full buffer can still accept when it is being popped this cycle.
        assign pop[h]  = load && grant_valid && (int'(grant) == h);
        assign push[h] = in_valid[h] && (!full[h] || pop[h]);
        assign drop[h] = in_valid[h] && full[h] && !pop[h];

        rvvi_retire_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk      (clk),
            .reset_n  (reset_n),
            .push     (push[h]),
            .pop      (pop[h]),
            .data_in  (entry_in),
            .data_out (head_bits[h]),
            .full     (full[h]),
            .empty    (empty[h])
        );

        // Dropped events are counted up to saturation; the flag is sticky.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                cnt_q  <= '0;
                flag_q <= 1'b0;
            end else if (drop[h]) begin
                if (cnt_q != OVF_CNT_MAX) begin
                    cnt_q <= cnt_q + OVF_CNT_W'(1);
                end
                flag_q <= 1'b1;
            end
        end

        assign ovf_cnt[h*OVF_CNT_W +: OVF_CNT_W] = cnt_q;
        assign ovf_flag[h]                       = flag_q;

`ifdef RVVI_ARB_ORDER_CHECK_EN
        logic [63:0] last_order;
        logic        seen;
        logic        err_q;

        // Only accepted pushes advance the reference; the very first one
        // after reset just seeds it.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                last_order <= '0;
                seen       <= 1'b0;
                err_q      <= 1'b0;
            end else if (push[h]) begin
                if (seen && (in_order[h*64 +: 64] != last_order + 64'd1)) begin
                    err_q <= 1'b1;
                end
                last_order <= in_order[h*64 +: 64];
                seen       <= 1'b1;
            end
        end

        assign order_err[h] = err_q;
`else
        assign order_err[h] = 1'b0;
`endif
    end

    // Output slot: fields change only on a load, so they hold while stalled.
    // When nothing is pending at load time the slot simply goes empty.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_hart  <= '0;
            out_pc    <= '0;
            out_insn  <= '0;
            out_order <= '0;
            out_trap  <= 1'b0;
            rr_ptr    <= '0;
        end else if (load) begin
            if (grant_valid) begin
                out_valid <= 1'b1;
                out_hart  <= grant;
                out_pc    <= head.pc;
                out_insn  <= head.insn;
                out_order <= head.order;
                out_trap  <= head.trap;
                if (int'(grant) == NHART - 1) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= grant + HW'(1);
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rvvi_retire_arbiter.sv
// Self-checking bench for rvvi_retire_arbiter (NHART=2, XLEN=64, DEPTH=4).
// A queue-based reference model advances once per clock edge and a compare
// process checks every cycle; directed scenarios add literal expectations.
// Define RVVI_ARB_ORDER_CHECK_EN for both bench and RTL to cover the
// order-check build.
module tb_rvvi_retire_arbiter;

    localparam int NHART = 2;
    localparam int XLEN  = 64;
    localparam int DEPTH = 4;
    localparam int HW    = 1;
`ifdef RVVI_ARB_ORDER_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [NHART-1:0]      in_valid;
    logic [NHART*XLEN-1:0] in_pc;
    logic [NHART*32-1:0]   in_insn;
    logic [NHART*64-1:0]   in_order;
    logic [NHART-1:0]      in_trap;
    logic                  out_valid;
    logic                  out_ready;
    logic [HW-1:0]         out_hart;
    logic [XLEN-1:0]       out_pc;
    logic [31:0]           out_insn;
    logic [63:0]           out_order;
    logic                  out_trap;
    logic [NHART*16-1:0]   ovf_cnt;
    logic [NHART-1:0]      ovf_flag;
    logic [NHART-1:0]      order_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rvvi_retire_arbiter #(
        .NHART (NHART),
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_insn   (in_insn),
        .in_order  (in_order),
        .in_trap   (in_trap),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hart  (out_hart),
        .out_pc    (out_pc),
        .out_insn  (out_insn),
        .out_order (out_order),
        .out_trap  (out_trap),
        .ovf_cnt   (ovf_cnt),
        .ovf_flag  (ovf_flag),
        .order_err (order_err)
    );

    // Reference model state
    typedef struct {
        logic [63:0] pc;
        logic [31:0] insn;
        logic [63:0] order;
        logic        trap;
    } ev_t;

    ev_t  mq [NHART][$];
    bit   model_ready = 1'b0;
    bit   m_valid;
    int   m_hart;
    ev_t  m_slot;
    int   m_rr;
    int   m_cnt [NHART];
    bit   m_flag [NHART];
    bit   m_err [NHART];
`ifdef RVVI_ARB_ORDER_CHECK_EN
    bit          m_seen [NHART];
    logic [63:0] m_last [NHART];
`endif

    logic [HW-1:0] xfer_harts [$];
    logic [63:0]   xfer_orders [$];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs presented to it.
    task automatic modelStep();
        if (!reset_n) begin
            for (int h = 0; h < NHART; h++) begin
                mq[h].delete();
                m_cnt[h]  = 0;
                m_flag[h] = 1'b0;
                m_err[h]  = 1'b0;
`ifdef RVVI_ARB_ORDER_CHECK_EN
                m_seen[h] = 1'b0;
                m_last[h] = '0;
`endif
            end
            m_valid     = 1'b0;
            m_hart      = 0;
            m_slot      = '{64'd0, 32'd0, 64'd0, 1'b0};
            m_rr        = 0;
            model_ready = 1'b1;
        end else begin
            if (!m_valid || out_ready) begin
                bit found;
                found = 1'b0;
                for (int i = 0; i < NHART; i++) begin
                    int h;
                    h = (m_rr + i) % NHART;
                    if (!found && mq[h].size() > 0) begin
                        found  = 1'b1;
                        m_slot = mq[h].pop_front();
                        m_hart = h;
                        m_rr   = (h + 1) % NHART;
                    end
                end
                m_valid = found;
            end
            for (int h = 0; h < NHART; h++) begin
                if (in_valid[h]) begin
                    ev_t e;
                    e.pc    = in_pc[h*XLEN +: XLEN];
                    e.insn  = in_insn[h*32 +: 32];
                    e.order = in_order[h*64 +: 64];
                    e.trap  = in_trap[h];
                    if (mq[h].size() < DEPTH) begin
                        mq[h].push_back(e);
`ifdef RVVI_ARB_ORDER_CHECK_EN
                        if (m_seen[h] && e.order != m_last[h] + 64'd1) m_err[h] = 1'b1;
                        m_last[h] = e.order;
                        m_seen[h] = 1'b1;
`endif
                    end else begin
                        if (m_cnt[h] < 65535) m_cnt[h]++;
                        m_flag[h] = 1'b1;
                    end
                end
            end
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, update the model.
    task automatic applyStimulus(input logic rst_n, input logic rdy, input logic [1:0] v,
                                 input logic [63:0] pc0, input logic [63:0] ord0,
                                 input logic [63:0] pc1, input logic [63:0] ord1);
        reset_n             = rst_n;
        out_ready           = rdy;
        in_valid            = v;
        in_pc[0 +: 64]      = pc0;
        in_pc[64 +: 64]     = pc1;
        in_order[0 +: 64]   = ord0;
        in_order[64 +: 64]  = ord1;
        in_insn[0 +: 32]    = {pc0[15:0], ord0[15:0]};
        in_insn[32 +: 32]   = {pc1[15:0], ord1[15:0]};
        in_trap             = {ord1[3], ord0[3]};
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b1, rdy, 2'b00, 0, 0, 0, 0);
    endtask

    // Compare process: DUT against model every cycle, and handshake log.
    initial begin
        forever begin
            @(negedge clk);
            if (model_ready) begin
                checkOutput("out_valid", out_valid, m_valid);
                if (m_valid) begin
                    checkOutput("out_hart", out_hart, m_hart);
                    checkOutput("out_pc", out_pc, m_slot.pc);
                    checkOutput("out_insn", out_insn, m_slot.insn);
                    checkOutput("out_order", out_order, m_slot.order);
                    checkOutput("out_trap", out_trap, m_slot.trap);
                end
                for (int h = 0; h < NHART; h++) begin
                    checkOutput("ovf_cnt", ovf_cnt[h*16 +: 16], m_cnt[h]);
                    checkOutput("ovf_flag", ovf_flag[h], m_flag[h]);
                    checkOutput("order_err", order_err[h], m_err[h]);
                end
                if (reset_n && out_valid && out_ready) begin
                    xfer_harts.push_back(out_hart);
                    xfer_orders.push_back(out_order);
                end
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        out_ready = 1'b0;
        in_valid  = '0;
        in_pc     = '0;
        in_insn   = '0;
        in_order  = '0;
        in_trap   = '0;
        applyStimulus(1'b0, 1'b0, 2'b00, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 2'b00, 0, 0, 0, 0);
        checkOutput("reset_valid", out_valid, 0);
        checkOutput("reset_ovf", ovf_cnt, 0);
        checkOutput("reset_flag", ovf_flag, 0);
        checkOutput("reset_err", order_err, 0);

        // Single event on hart 1
        $display("[TB] single event latency");
        xfer_harts.delete(); xfer_orders.delete();
        applyStimulus(1'b1, 1'b1, 2'b10, 0, 0, 64'h8000_0000, 5);
        checkOutput("t1_not_yet", out_valid, 0);
        idle(1'b1, 1);
        checkOutput("t1_valid", out_valid, 1);
        checkOutput("t1_hart", out_hart, 1);
        checkOutput("t1_pc", out_pc, 64'h8000_0000);
        checkOutput("t1_order", out_order, 5);
        idle(1'b1, 1);
        checkOutput("t1_drained", out_valid, 0);
        idle(1'b1, 2);
        checkOutput("t1_xfers", xfer_harts.size(), 1);

        // Both harts every cycle: alternating output, no drops
        $display("[TB] round-robin alternation");
        xfer_harts.delete(); xfer_orders.delete();
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, 1'b1, 2'b11, 64'h1000 + 4*c, 100 + c, 64'h2000 + 4*c, 200 + c);
        end
        idle(1'b1, 8);
        checkOutput("t2_xfers", xfer_harts.size(), 8);
        if (xfer_harts.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                checkOutput("t2_hart", xfer_harts[i], i % 2);
                checkOutput("t2_order", xfer_orders[i], ((i % 2) ? 200 : 100) + i / 2);
            end
        end
        checkOutput("t2_ovf", ovf_cnt, 0);

        // Overflow with the slot stalled
        $display("[TB] overflow");
        applyStimulus(1'b0, 1'b0, 2'b00, 0, 0, 0, 0);
        xfer_harts.delete(); xfer_orders.delete();
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1'b1, 1'b0, 2'b01, 64'h3000 + 4*k, k, 0, 0);
        end
        checkOutput("t3_ovf_cnt", ovf_cnt[15:0], 1);
        checkOutput("t3_ovf_flag", ovf_flag, 2'b01);
        checkOutput("t3_valid", out_valid, 1);
        checkOutput("t3_order", out_order, 1);

        // Push into full buffer while it is popped: accepted
        $display("[TB] push and pop while full");
        applyStimulus(1'b1, 1'b1, 2'b01, 64'h3000 + 28, 7, 0, 0);
        checkOutput("t4_ovf_cnt", ovf_cnt[15:0], 1);
        idle(1'b1, 8);
        checkOutput("t4_xfers", xfer_orders.size(), 6);
        if (xfer_orders.size() == 6) begin
            checkOutput("t4_o0", xfer_orders[0], 1);
            checkOutput("t4_o3", xfer_orders[3], 4);
            checkOutput("t4_o4", xfer_orders[4], 5);
            checkOutput("t4_o5", xfer_orders[5], 7);
        end

        // Stall hold and mid-stream reset
        $display("[TB] stall hold and reset");
        applyStimulus(1'b0, 1'b0, 2'b00, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 2'b10, 0, 0, 64'h8000_1000, 20);
        idle(1'b0, 1);
        for (int k = 0; k < 3; k++) begin
            idle(1'b0, 1);
            checkOutput("t5_hold_valid", out_valid, 1);
            checkOutput("t5_hold_hart", out_hart, 1);
            checkOutput("t5_hold_pc", out_pc, 64'h8000_1000);
            checkOutput("t5_hold_order", out_order, 20);
        end
        applyStimulus(1'b1, 1'b0, 2'b11, 64'h4000, 30, 64'h4004, 21);
        applyStimulus(1'b0, 1'b0, 2'b00, 0, 0, 0, 0);
        checkOutput("t5_reset_valid", out_valid, 0);
        idle(1'b1, 1);
        checkOutput("t5_empty1", out_valid, 0);
        idle(1'b1, 1);
        checkOutput("t5_empty2", out_valid, 0);

        // Order check
        $display("[TB] order check");
        applyStimulus(1'b0, 1'b1, 2'b00, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b1, 2'b01, 64'h5000, 10, 0, 0);
        checkOutput("t6_err_10", order_err[0], 0);
        applyStimulus(1'b1, 1'b1, 2'b01, 64'h5004, 11, 0, 0);
        checkOutput("t6_err_11", order_err[0], 0);
        applyStimulus(1'b1, 1'b1, 2'b01, 64'h5008, 13, 0, 0);
        checkOutput("t6_err_13", order_err[0], ERR_EXP);
        idle(1'b1, 2);
        checkOutput("t6_err_sticky", order_err[0], ERR_EXP);
        checkOutput("t6_err_h1", order_err[1], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
